// File: rtl/spi_master_ctl.sv
// Memory-mapped SPI master (mode 0, MSB first) with byte-wide TX/RX FIFOs and manual chip-select.
// Define SPI_IRQ_EN to enable the registered level interrupt and the CTRL.IE bit.

module spi_master_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & ~do_push;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

module spi_master_ctl #(
    parameter logic [31:0] SPI_BASE_ADDR = 32'h4000_4000,
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [7:0]  DIV_RESET     = 8'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        irq
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic       hit_data, hit_status, hit_ctrl, hit_any;
    logic       we_q, re_q, wr_stb, rd_stb, ctrl_wr, status_wr;
    logic [7:0] div_q, div_d;
    logic       en_q, en_d, cs_q, cs_d, ie_rd;
    logic       tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic [1:0] state_q, state_d;
    logic [7:0] hp_cnt_q, hp_cnt_d, div_act_q, div_act_d;
    logic [7:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sclk_q, sclk_d, mosi_q, mosi_d, busy;
    logic       tx_push, tx_pop, tx_full, tx_empty, tx_drop;
    logic       rx_push, rx_pop, rx_full, rx_empty, rx_drop;
    logic [7:0] tx_head, rx_head;

    assign hit_data   = (mem_addr == SPI_BASE_ADDR);
    assign hit_status = (mem_addr == SPI_BASE_ADDR + 32'h4);
    assign hit_ctrl   = (mem_addr == SPI_BASE_ADDR + 32'h8);
    assign hit_any    = hit_data | hit_status | hit_ctrl;

    // Strobes held for several cycles act only once, on their first cycle.
    assign wr_stb    = mem_we & hit_any & ~we_q;
    assign rd_stb    = mem_re & hit_any & ~re_q;
    assign ctrl_wr   = wr_stb & hit_ctrl;
    assign status_wr = wr_stb & hit_status;
    assign tx_push   = wr_stb & hit_data;
    assign rx_pop    = rd_stb & hit_data;

    assign div_d    = ctrl_wr ? mem_wdata[7:0] : div_q;
    assign en_d     = ctrl_wr ? mem_wdata[8]   : en_q;
    assign cs_d     = ctrl_wr ? mem_wdata[9]   : cs_q;
    assign tx_ovf_d = (tx_ovf_q & ~(status_wr & mem_wdata[6])) | tx_drop;
    assign rx_ovf_d = (rx_ovf_q & ~(status_wr & mem_wdata[5])) | rx_drop;
    assign busy     = (state_q != ST_IDLE);

    spi_master_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push_i(tx_push), .pop_i(tx_pop), .wdata_i(mem_wdata[7:0]),
        .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .drop_o(tx_drop)
    );

    spi_master_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(rx_pop), .wdata_i(rx_shift_q),
        .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .drop_o(rx_drop)
    );

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        hp_cnt_d   = hp_cnt_q;
        div_act_d  = div_act_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_q && !tx_empty) begin
                    tx_pop     = 1'b1;
                    state_d    = ST_XFER;
                    tx_shift_d = tx_head;
                    mosi_d     = tx_head[7];
                    sclk_d     = 1'b0;
                    hp_cnt_d   = 8'd0;
                    bit_cnt_d  = 3'd0;
                    div_act_d  = div_q;
                end
            end
            ST_XFER: begin
                if (hp_cnt_q == div_act_q) begin
                    // A new DIV is picked up only here, so a half-period is never cut short.
                    hp_cnt_d  = 8'd0;
                    div_act_d = div_q;
                    sclk_d    = ~sclk_q;
                    if (!sclk_q) begin
                        rx_shift_d = {rx_shift_q[6:0], spi_miso};
                    end else if (bit_cnt_q == 3'd7) begin
                        state_d = ST_DONE;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        mosi_d     = tx_shift_q[6];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                rx_push = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            div_q      <= DIV_RESET;
            en_q       <= 1'b0;
            cs_q       <= 1'b0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            state_q    <= ST_IDLE;
            hp_cnt_q   <= 8'd0;
            div_act_q  <= DIV_RESET;
            bit_cnt_q  <= 3'd0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            tx_shift_q <= 8'd0;
            rx_shift_q <= 8'd0;
        end else begin
            we_q       <= mem_we & hit_any;
            re_q       <= mem_re & hit_any;
            div_q      <= div_d;
            en_q       <= en_d;
            cs_q       <= cs_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            state_q    <= state_d;
            hp_cnt_q   <= hp_cnt_d;
            div_act_q  <= div_act_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
        end
    end

`ifdef SPI_IRQ_EN
    logic ie_q, ie_d, irq_q, irq_d;
    logic unused_wdata;
    assign ie_d  = ctrl_wr ? mem_wdata[10] : ie_q;
    assign irq_d = ie_q & (~rx_empty | (tx_empty & ~busy));
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end
    assign ie_rd        = ie_q;
    assign irq          = irq_q;
    assign unused_wdata = ^mem_wdata[31:11];
`else
    logic unused_wdata;
    assign ie_rd        = 1'b0;
    assign irq          = 1'b0;
    assign unused_wdata = ^mem_wdata[31:10];
`endif

    always_comb begin
        mem_rdata = 32'd0;
        if (hit_data) begin
            mem_rdata = {24'd0, rx_empty ? 8'd0 : rx_head};
        end else if (hit_status) begin
            mem_rdata = {25'd0, tx_ovf_q, rx_ovf_q, rx_empty, rx_full, tx_empty, tx_full, busy};
        end else if (hit_ctrl) begin
            mem_rdata = {21'd0, ie_rd, cs_q, en_q, div_q};
        end
    end

    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = ~cs_q;
endmodule

// File: tb/tb_spi_master_ctl.sv
// Directed self-checking bench for spi_master_ctl with MISO looped back to MOSI.
// Expectations follow the SPI_IRQ_EN setting of the build.

module tb_spi_master_ctl;
    localparam logic [31:0] BASE   = 32'h4000_4000;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
`ifdef SPI_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic [31:0] mem_rdata;
    logic        spi_sclk, spi_mosi, spi_cs_n, irq;

    int n_checks = 0;
    int n_fail   = 0;

    spi_master_ctl dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_mosi),
        .spi_cs_n(spi_cs_n), .irq(irq)
    );

    always #5 clk = ~clk;

    // SCLK monitor: run lengths of each level, cycle stamps of edges, MOSI at each rising edge.
    int   hi_runs[$];
    int   lo_runs[$];
    int   rise_cyc[$];
    int   fall_cyc[$];
    logic mosi_bits[$];
    logic sclk_prev = 1'b0;
    int   run_len = 0;
    int   cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (spi_sclk !== sclk_prev) begin
            if (sclk_prev === 1'b1) begin
                hi_runs.push_back(run_len);
                fall_cyc.push_back(cyc);
            end else begin
                if (rise_cyc.size() > 0) lo_runs.push_back(run_len);
                rise_cyc.push_back(cyc);
                mosi_bits.push_back(spi_mosi);
            end
            run_len = 1;
        end else begin
            run_len++;
        end
        sclk_prev = spi_sclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        @(negedge clk);
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        mem_addr = a;
        mem_re   = 1'b1;
        #1 d = mem_rdata;
        @(negedge clk);
        mem_re   = 1'b0;
        mem_addr = 32'd0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // Poll STATUS until BUSY=0 (and TX_EMPTY=1 when need_tx_empty); a timeout is a failed check.
    task automatic wait_status(input string tag, input bit need_tx_empty);
        logic [31:0] s;
        bit done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            bus_read(A_STAT, s);
            if (!s[0] && (s[2] || !need_tx_empty)) done = 1'b1;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_rises(input string tag, input int n);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (rise_cyc.size() >= n) done = 1'b1;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic clear_mon();
        hi_runs.delete();
        lo_runs.delete();
        rise_cyc.delete();
        fall_cyc.delete();
        mosi_bits.delete();
    endtask

    function automatic logic [7:0] mosi_byte();
        logic [7:0] b = 8'd0;
        for (int i = 0; i < 8 && i < mosi_bits.size(); i++) b[7-i] = mosi_bits[i];
        return b;
    endfunction

    task automatic check_runs(input string tag, input int half, input int nbits);
        check({tag, "_rises"}, rise_cyc.size(), nbits);
        check({tag, "_falls"}, fall_cyc.size(), nbits);
        foreach (hi_runs[i]) check($sformatf("%s_hi%0d", tag, i), hi_runs[i], half);
        foreach (lo_runs[i]) check($sformatf("%s_lo%0d", tag, i), lo_runs[i], half);
    endtask

    initial begin
        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        read_check("rst_status", A_STAT, 32'h14);
        read_check("rst_ctrl", A_CTRL, 32'h003);
        read_check("out_of_window", BASE + 32'hC, 32'd0);

        // Single byte 0xA5, DIV=0: one clk high, one clk low per SCLK period.
        clear_mon();
        bus_write(A_CTRL, 32'h300);
        check("cs_asserted", {31'd0, spi_cs_n}, 32'd0);
        bus_write(A_DATA, 32'hA5);
        wait_status("a5_idle", 1'b1);
        check_runs("a5", 1, 8);
        check("a5_mosi", {24'd0, mosi_byte()}, 32'hA5);
        check("a5_sclk_idle", {31'd0, spi_sclk}, 32'd0);
        read_check("a5_rx", A_DATA, 32'hA5);
        read_check("a5_status", A_STAT, 32'h14);

        // TX overflow with EN=0, then W1C of TX_OVF.
        bus_write(A_CTRL, 32'h200);
        bus_write(A_DATA, 32'h11);
        bus_write(A_DATA, 32'h22);
        bus_write(A_DATA, 32'h33);
        bus_write(A_DATA, 32'h44);
        bus_write(A_DATA, 32'h55);
        read_check("txovf_status", A_STAT, 32'h52);
        bus_write(A_STAT, 32'h40);
        read_check("txovf_cleared", A_STAT, 32'h12);

        // Four bytes fill RX, a fifth is dropped and sets RX_OVF.
        bus_write(A_CTRL, 32'h300);
        wait_status("fill_idle", 1'b1);
        read_check("rx_full_status", A_STAT, 32'h0C);
        bus_write(A_DATA, 32'h66);
        wait_status("rxovf_idle", 1'b1);
        read_check("rxovf_status", A_STAT, 32'h2C);
        read_check("rx0", A_DATA, 32'h11);
        read_check("rx1", A_DATA, 32'h22);
        read_check("rx2", A_DATA, 32'h33);
        read_check("rx3", A_DATA, 32'h44);
        read_check("rx_drained_status", A_STAT, 32'h34);
        read_check("rx_empty_read", A_DATA, 32'd0);
        bus_write(A_STAT, 32'h20);
        read_check("rxovf_cleared", A_STAT, 32'h14);

        // DIV=3: 4-clk half periods; EN dropped mid-byte lets the byte finish but starts no other.
        bus_write(A_CTRL, 32'h203);
        bus_write(A_DATA, 32'h3C);
        bus_write(A_DATA, 32'hC3);
        clear_mon();
        bus_write(A_CTRL, 32'h303);
        wait_rises("div3_rise3", 3);
        bus_write(A_CTRL, 32'h203);
        wait_status("div3_done", 1'b0);
        repeat (100) @(negedge clk);
        check_runs("div3", 4, 8);
        check("div3_span", (fall_cyc.size() == 8 && rise_cyc.size() > 0) ? fall_cyc[7] - rise_cyc[0] : -1, 60);
        check("div3_mosi", {24'd0, mosi_byte()}, 32'h3C);
        read_check("div3_status", A_STAT, 32'h00);
        read_check("div3_rx", A_DATA, 32'h3C);

        // Reset in the middle of a byte aborts it.
        clear_mon();
        bus_write(A_CTRL, 32'h303);
        wait_rises("abort_rise3", 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_sclk", {31'd0, spi_sclk}, 32'd0);
        check("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        read_check("abort_status", A_STAT, 32'h14);
        read_check("abort_ctrl", A_CTRL, 32'h003);

        // Interrupt behaviour; a build without SPI_IRQ_EN keeps irq low and CTRL[10] at 0.
        bus_write(A_CTRL, 32'h403);
        read_check("ie_readback", A_CTRL, IRQ_BUILD ? 32'h403 : 32'h003);
        repeat (2) @(negedge clk);
        check("irq_tx_empty_idle", {31'd0, irq}, {31'd0, IRQ_BUILD});
        bus_write(A_DATA, 32'h5A);
        repeat (2) @(negedge clk);
        check("irq_tx_pending", {31'd0, irq}, 32'd0);
        bus_write(A_CTRL, 32'h703);
        wait_status("irq_xfer_idle", 1'b1);
        check("irq_rx_ready", {31'd0, irq}, {31'd0, IRQ_BUILD});
        read_check("irq_rx", A_DATA, 32'h5A);
        repeat (2) @(negedge clk);
        check("irq_after_drain", {31'd0, irq}, {31'd0, IRQ_BUILD});
        bus_write(A_CTRL, 32'h303);
        repeat (2) @(negedge clk);
        check("irq_ie_off", {31'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog");
    end
endmodule
